// File: rtl/reg_general_pkg.sv
// Shared register-file types and defaults.
// Imported by reg_general_16 and reg_general_parity.
package reg_general_pkg;
   localparam int REG_WIDTH_DEFAULT = 16;
   localparam logic [REG_WIDTH_DEFAULT-1:0] REG_RESET_DEFAULT = 16'h0000;
   typedef logic [REG_WIDTH_DEFAULT-1:0] reg_word_t;
endpackage

// File: rtl/reg_general_parity.sv
// Even-parity generator for incoming data and checker for stored data.
// Used by reg_general_16 only when REG_GENERAL_PARITY_EN is defined.
module reg_general_parity
   import reg_general_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] gen_data,
   input  logic [WIDTH-1:0] chk_data,
   input  logic             chk_par,
   output logic             gen_par,
   output logic             err
);
   assign gen_par = ^gen_data;
   assign err     = (^chk_data) ^ chk_par;
endmodule

// File: rtl/reg_general_16.sv
// General-purpose storage register with load enable and async active-low reset.
// Optional stored even parity and parity_err output under REG_GENERAL_PARITY_EN.
module reg_general_16
   import reg_general_pkg::*;
#(
   parameter int              WIDTH       = REG_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
`ifdef REG_GENERAL_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef REG_GENERAL_PARITY_EN
   localparam logic RESET_PAR = ^RESET_VALUE;

   logic par_q;
   logic par_d;

   reg_general_parity #(
      .WIDTH    (WIDTH)
   ) u_parity (
      .gen_data (d_in),
      .chk_data (d_out),
      .chk_par  (par_q),
      .gen_par  (par_d),
      .err      (parity_err)
   );
`endif

   // Storage: reset wins, otherwise capture on load, otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_out <= RESET_VALUE;
`ifdef REG_GENERAL_PARITY_EN
         par_q <= RESET_PAR;
`endif
      end else if (load) begin
         d_out <= d_in;
`ifdef REG_GENERAL_PARITY_EN
         par_q <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_reg_general_16.sv
// Scoreboard bench for reg_general_16: directed cases then random traffic.
// Define REG_GENERAL_PARITY_EN to also exercise the parity flag.
module tb_reg_general_16;
   import reg_general_pkg::*;

   logic      clk;
   logic      rst;
   logic      load;
   reg_word_t d_in;
   reg_word_t d_out;
`ifdef REG_GENERAL_PARITY_EN
   logic      parity_err;
`endif

   reg_general_16 dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .d_in       (d_in),
      .d_out      (d_out)
`ifdef REG_GENERAL_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   int        checks = 0;
   int        errors = 0;
   reg_word_t model  = 16'h0000;
   reg_word_t sb_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input reg_word_t got,
                      input reg_word_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want,
                  $time);
      end
   endtask

   // Monitor: the register is observable every cycle; compare mid-cycle.
   always @(negedge clk) begin
      reg_word_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("d_out_sb", d_out, e);
      end
   end

   // One cycle of stimulus, issued 1 ns after a rising edge.
   // pulse=1 adds a short rst low pulse after the falling clk edge.
   task automatic cycle(input logic r, input logic l, input reg_word_t d,
                        input logic pulse);
      rst  = r;
      load = l;
      d_in = d;
      if (!r) begin
         model = 16'h0000;
         #1;
         chk("async_assert", d_out, 16'h0000);
      end
      sb_q.push_back(model);
      if (pulse && r) begin
         @(negedge clk);
         #1;
         rst = 1'b0;
         model = 16'h0000;
         #1;
         chk("async_mid", d_out, 16'h0000);
         #1;
         rst = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!r) model = 16'h0000;
      else if (l) model = d;
   endtask

   initial begin
      reg_word_t x_word;
      x_word = 'x;
      rst  = 1'b0;
      load = 1'b0;
      d_in = x_word;
      #1;
      chk("reset_t0", d_out, 16'h0000);
      @(posedge clk);
      #1;

      cycle(1'b1, 1'b0, x_word, 1'b0);
      cycle(1'b1, 1'b1, 16'hAAAA, 1'b0);
      cycle(1'b1, 1'b0, 16'hBBBB, 1'b0);
      cycle(1'b1, 1'b1, 16'hBBBB, 1'b0);
      cycle(1'b1, 1'b0, 16'h5555, 1'b0);
      cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
      cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      cycle(1'b1, 1'b1, 16'h1234, 1'b0);
      cycle(1'b1, 1'b0, 16'hCAFE, 1'b1);
      cycle(1'b1, 1'b0, 16'hCAFE, 1'b0);

      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
               16'($urandom), $urandom_range(0, 19) == 0);
      end

`ifdef REG_GENERAL_PARITY_EN
      cycle(1'b1, 1'b1, 16'h0001, 1'b0);
      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("par_ok", {15'd0, parity_err}, 16'h0000);
      force dut.par_q = 1'b0;
      #1;
      chk("par_flip", {15'd0, parity_err}, 16'h0001);
      release dut.par_q;
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("par_reset", {15'd0, parity_err}, 16'h0000);
`endif

      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
